fetch_queue: RTL and testbench

Parametrised first-word-fall-through instruction queue between the fetch unit and decode, carrying `{pc, instr}` beats under valid/ready handshakes on both sides. It generalises the single-entry fetch/decode skid stage to `DEPTH` entries. It adds a synchronous `flush` for front-end redirects (branch/jump) and exposes occupancy status. `ready_in` depends only on registered state, so there is no combinational path from `ready_out` to `ready_in`.

---
 rtl/fetch_queue.sv | 74 +++++++
 tb/tb_fetch_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction queue between fetch and decode.
// Holds DEPTH {pc, instr} beats; flush drops everything queued or offered this cycle.
module fetch_queue #(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wp_q, wp_d;
  logic [PTR_W-1:0]      rp_q, rp_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;

  // Status comes only from registered occupancy, so ready_in never sees ready_out.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign ready_in  = !full;
  assign valid_out = !empty;
  assign data_out  = mem_q[rp_q];
  assign count     = count_q;

  assign push = valid_in && ready_in;
  assign pop  = valid_out && ready_out;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      if (push && !flush) mem_q[wp_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, fill/stall, random wrap, flush, async reset.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic        ready_in;
  logic [63:0] data_in;
  logic        valid_out;
  logic        ready_out;
  logic [63:0] data_out;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] b [6];
  logic [63:0] sb [$];

  fetch_queue #(.DATA_WIDTH(64), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int rcvd;
    int cyc;
    logic mpush, mpop;
    logic [63:0] beat;

    b[0] = {32'h0000_0000, 32'h0000_0013};
    b[1] = {32'h0000_0004, 32'h0020_0093};
    b[2] = {32'h0000_0008, 32'h0030_0113};
    b[3] = {32'h0000_000C, 32'h0020_81B3};
    b[4] = {32'h0000_0010, 32'h0000_0067};
    b[5] = {32'h0000_0014, 32'h0010_0073};

    // Reset held with an offered beat
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b1; ready_out = 1'b0;
    data_in = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (5) step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd1);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    valid_in = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_empty", 64'(empty), 64'd1);

    // Streaming with ready_out high
    ready_out = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      data_in  = b[i];
      step();
      check("stream_valid", 64'(valid_out), 64'd1);
      check("stream_data", data_out, b[i]);
      check("stream_count", 64'(count), 64'd1);
    end
    valid_in = 1'b0;
    step();
    check("stream_drain_empty", 64'(empty), 64'd1);

    // Fill and stall
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      data_in  = b[i];
      check("fill_ready_in", 64'(ready_in), 64'd1);
      step();
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready_in_low", 64'(ready_in), 64'd0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_head", data_out, b[0]);
    data_in = b[4];
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_count", 64'(count), 64'd4);
      check("stall_head", data_out, b[0]);
      check("stall_ready_in", 64'(ready_in), 64'd0);
    end
    ready_out = 1'b1;
    check("pop_full_ready_in", 64'(ready_in), 64'd0);
    step();
    check("pop1_count", 64'(count), 64'd3);
    check("pop1_ready_in", 64'(ready_in), 64'd1);
    check("pop1_head", data_out, b[1]);
    step();
    check("pop2_count", 64'(count), 64'd3);
    check("pop2_head", data_out, b[2]);
    data_in = b[5];
    step();
    check("pop3_count", 64'(count), 64'd3);
    check("pop3_head", data_out, b[3]);
    valid_in = 1'b0;
    step();
    check("pop4_count", 64'(count), 64'd2);
    check("pop4_head", data_out, b[4]);
    step();
    check("pop5_count", 64'(count), 64'd1);
    check("pop5_head", data_out, b[5]);
    step();
    check("pop6_empty", 64'(empty), 64'd1);

    // Wrap-around with random backpressure against a queue model
    sent = 0; rcvd = 0; cyc = 0;
    sb.delete();
    while (rcvd < 13 && cyc < 2000) begin
      beat      = {32'(32'h200 + 4 * sent), 32'(sent * 32'h0001_1111)};
      valid_in  = (sent < 13) && ($urandom_range(0, 1) == 1);
      data_in   = beat;
      ready_out = ($urandom_range(0, 2) != 0);
      check("wrap_ready_in", 64'(ready_in), 64'(sb.size() < 4));
      check("wrap_valid_out", 64'(valid_out), 64'(sb.size() > 0));
      if (sb.size() > 0) check("wrap_data", data_out, sb[0]);
      mpush = valid_in && (sb.size() < 4);
      mpop  = ready_out && (sb.size() > 0);
      step();
      if (mpop) begin
        void'(sb.pop_front());
        rcvd++;
      end
      if (mpush) begin
        sb.push_back(beat);
        sent++;
      end
      check("wrap_count", 64'(count), 64'(sb.size()));
      cyc++;
    end
    check("wrap_done", 64'(rcvd), 64'd13);
    valid_in = 1'b0;
    ready_out = 1'b0;

    // Flush with three queued beats while both handshakes are high
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in  = b[i];
      step();
    end
    check("preflush_count", 64'(count), 64'd3);
    flush = 1'b1; valid_in = 1'b1; data_in = b[3]; ready_out = 1'b1;
    step();
    flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid_out", 64'(valid_out), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    valid_in = 1'b1;
    data_in  = {32'h0000_0100, 32'h0000_0013};
    check("postflush_ready_in", 64'(ready_in), 64'd1);
    step();
    valid_in = 1'b0;
    check("postflush_valid", 64'(valid_out), 64'd1);
    check("postflush_data", data_out, {32'h0000_0100, 32'h0000_0013});
    check("postflush_count", 64'(count), 64'd1);
    ready_out = 1'b1;
    step();
    check("postflush_drain", 64'(empty), 64'd1);
    ready_out = 1'b0;

    // Asynchronous reset between edges with two beats queued
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1;
      data_in  = b[i + 2];
      step();
    end
    valid_in = 1'b0;
    check("premid_count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", 64'(valid_out), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_data_out", data_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("midrst_release_empty", 64'(empty), 64'd1);
    check("midrst_release_ready", 64'(ready_in), 64'd1);
    valid_in = 1'b1;
    data_in  = b[5];
    step();
    valid_in = 1'b0;
    check("midrst_push_data", data_out, b[5]);
    check("midrst_push_count", 64'(count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
